score_table_ctrl: RTL and testbench

- Parametrised RAM-backed score table controller for the game datapath.
- Accepts update and dump commands over a valid/ready handshake.
- Update: read-modify-write of one player's entry, using a configurable merge mode.
- Dump: streams every entry as {id, score} with valid/ready backpressure and a last flag, then returns to IDLE.
- Sits between game-state control and the single-port score RAM; feeds the scoreboard display path.

---
 rtl/score_table_pkg.sv | 22 ++
 rtl/score_merge.sv | 27 ++
 rtl/score_table_ctrl.sv | 144 ++++++++++++++
 tb/tb_score_table_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_table_pkg.sv
// Shared opcodes, merge modes and controller state encodings for the score table.
package score_table_pkg;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_UPDATE = 2'b01;
  localparam logic [1:0] OP_DUMP   = 2'b10;

  localparam int MODE_OVERWRITE = 0;
  localparam int MODE_MAX       = 1;
  localparam int MODE_SAT_ADD   = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_UPD_RD    = 3'd1,
    ST_UPD_WAIT  = 3'd2,
    ST_UPD_WR    = 3'd3,
    ST_DUMP_RD   = 3'd4,
    ST_DUMP_WAIT = 3'd5,
    ST_DUMP_OUT  = 3'd6
  } state_e;

endpackage

// File: rtl/score_merge.sv
// Combinational merge of a stored score with an incoming score; rule fixed by MODE.
module score_merge
  import score_table_pkg::*;
#(
  parameter int SCORE_W = 16,
  parameter int MODE    = MODE_OVERWRITE
) (
  input  logic [SCORE_W-1:0] old_score,
  input  logic [SCORE_W-1:0] new_score,
  output logic [SCORE_W-1:0] merged
);

  logic [SCORE_W:0] sum;

  assign sum = {1'b0, old_score} + {1'b0, new_score};

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    merged = new_score;
    case (MODE)
      MODE_MAX:     merged = (new_score > old_score) ? new_score : old_score;
      MODE_SAT_ADD: merged = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
      default:      merged = new_score;
    endcase
  end

endmodule

// File: rtl/score_table_ctrl.sv
// Score table controller: read-modify-write updates and a backpressured full-table dump
// against a single-port RAM with fixed read latency; one RAM access outstanding at a time.
module score_table_ctrl
  import score_table_pkg::*;
#(
  parameter int ID_W    = 16,
  parameter int SCORE_W = 16,
  parameter int DEPTH   = 256,
  parameter int RAM_LAT = 2,
  parameter int MODE    = MODE_OVERWRITE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [ID_W-1:0]         cmd_id,
  input  logic [SCORE_W-1:0]      cmd_score,
  output logic [ID_W-1:0]         ram_addr,
  output logic [SCORE_W-1:0]      ram_wdata,
  output logic                    ram_wren,
  input  logic [SCORE_W-1:0]      ram_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ID_W+SCORE_W-1:0] out_data,
  output logic                    out_last,
  output logic                    err,
  output logic                    busy
);

  localparam int               CNT_W    = $clog2(RAM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RAM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ID_W:0]    ID_LIMIT = (ID_W + 1)'(DEPTH);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(DEPTH - 1);

  logic [2:0]         state;
  logic [CNT_W-1:0]   lat_cnt;
  logic [ID_W-1:0]    ptr;
  logic [SCORE_W-1:0] upd_score;
  logic [SCORE_W-1:0] merged;
  logic               id_ok;

  // Extra top bit lets DEPTH == 2**ID_W accept every id.
  assign id_ok     = ({1'b0, cmd_id} < ID_LIMIT);
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  score_merge #(
    .SCORE_W (SCORE_W),
    .MODE    (MODE)
  ) u_merge (
    .old_score (ram_rdata),
    .new_score (upd_score),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      lat_cnt   <= '0;
      ptr       <= '0;
      upd_score <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wren  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ram_wren <= 1'b0;
      err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_UPDATE: begin
                if (id_ok) begin
                  ram_addr  <= cmd_id;
                  upd_score <= cmd_score;
                  state     <= ST_UPD_RD;
                end else begin
                  err <= 1'b1;
                end
              end
              OP_DUMP: begin
                ptr      <= '0;
                ram_addr <= '0;
                state    <= ST_DUMP_RD;
              end
              default: ;
            endcase
          end
        end
        ST_UPD_RD: begin
          lat_cnt <= LAT_LOAD;
          state   <= ST_UPD_WAIT;
        end
        ST_UPD_WAIT: begin
          lat_cnt <= lat_cnt - CNT_ONE;
          // Read data is valid on the edge the counter reaches zero.
          if (lat_cnt == CNT_ONE) begin
            ram_wdata <= merged;
            ram_wren  <= 1'b1;
            state     <= ST_UPD_WR;
          end
        end
        ST_UPD_WR: begin
          state <= ST_IDLE;
        end
        ST_DUMP_RD: begin
          lat_cnt <= LAT_LOAD;
          state   <= ST_DUMP_WAIT;
        end
        ST_DUMP_WAIT: begin
          lat_cnt <= lat_cnt - CNT_ONE;
          if (lat_cnt == CNT_ONE) begin
            out_data  <= {ptr, ram_rdata};
            out_valid <= 1'b1;
            out_last  <= (ptr == LAST_ID);
            state     <= ST_DUMP_OUT;
          end
        end
        ST_DUMP_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state <= ST_IDLE;
            end else begin
              ptr      <= ptr + ID_W'(1);
              ram_addr <= ptr + ID_W'(1);
              state    <= ST_DUMP_RD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_table_ctrl.sv
// Scoreboard bench: three controller builds (sat-add/lat2, max/lat4, overwrite/depth4/lat1),
// each on its own RAM model; stimulus queues expected RAM writes, dump entries and err pulses.
module tb_score_table_ctrl;
  import score_table_pkg::*;

  localparam int N = 3;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : (g == 1) ? 4 : 1;
  endfunction
  function automatic int mode_of(input int g);
    return (g == 0) ? MODE_SAT_ADD : (g == 1) ? MODE_MAX : MODE_OVERWRITE;
  endfunction
  function automatic int depth_of(input int g);
    return (g == 2) ? 4 : 256;
  endfunction

  typedef enum logic [1:0] {EV_WR = 2'd0, EV_OUT = 2'd1, EV_ERR = 2'd2} ev_kind_e;
  typedef struct {
    int          inst;
    ev_kind_e    kind;
    logic [15:0] addr;
    logic [15:0] data;
    logic        last;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [N];
  logic        cmd_valid [N];
  logic        cmd_ready [N];
  logic [1:0]  cmd_op    [N];
  logic [15:0] cmd_id    [N];
  logic [15:0] cmd_score [N];
  logic [15:0] ram_addr  [N];
  logic [15:0] ram_wdata [N];
  logic        ram_wren  [N];
  logic [15:0] ram_rdata [N];
  logic        out_valid [N];
  logic        out_ready [N];
  logic [31:0] out_data  [N];
  logic        out_last  [N];
  logic        err       [N];
  logic        busy      [N];
  logic        pre_en    [N];
  logic [15:0] pre_addr;
  logic [15:0] pre_data;

  int  errors = 0;
  int  checks = 0;
  ev_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic void expect_ev(input int inst, input ev_kind_e kind,
                                    input logic [15:0] addr, input logic [15:0] data,
                                    input logic last);
    ev_t e;
    e.inst = inst; e.kind = kind; e.addr = addr; e.data = data; e.last = last;
    exp_q.push_back(e);
  endfunction

  task automatic observe(input int inst, input ev_kind_e kind, input logic [15:0] addr,
                         input logic [15:0] data, input logic last);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: inst=%0d kind=%0d addr=%0h data=%0h last=%0b, expected none",
               inst, kind, addr, data, last);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("event_i%0d_k%0d", e.inst, e.kind),
            {4'(inst), kind, addr, data, last}, {4'(e.inst), e.kind, e.addr, e.data, e.last});
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = lat_of(g);
    logic [15:0] mem     [65536];
    logic [15:0] rd_pipe [LAT];
    logic        prev_stall;
    logic [33:0] held;

    score_table_ctrl #(
      .ID_W    (16),
      .SCORE_W (16),
      .DEPTH   (depth_of(g)),
      .RAM_LAT (LAT),
      .MODE    (mode_of(g))
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .cmd_valid (cmd_valid[g]),
      .cmd_ready (cmd_ready[g]),
      .cmd_op    (cmd_op[g]),
      .cmd_id    (cmd_id[g]),
      .cmd_score (cmd_score[g]),
      .ram_addr  (ram_addr[g]),
      .ram_wdata (ram_wdata[g]),
      .ram_wren  (ram_wren[g]),
      .ram_rdata (ram_rdata[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .out_last  (out_last[g]),
      .err       (err[g]),
      .busy      (busy[g])
    );

    always @(posedge clk) begin
      if (pre_en[g]) mem[pre_addr] <= pre_data;
      else if (ram_wren[g]) mem[ram_addr[g]] <= ram_wdata[g];
      rd_pipe[0] <= mem[ram_addr[g]];
      for (int j = 1; j < LAT; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
    assign ram_rdata[g] = rd_pipe[LAT-1];

    always @(negedge clk) begin
      if (!rst[g]) begin
        prev_stall <= 1'b0;
      end else begin
        if (prev_stall)
          check($sformatf("stall_hold%0d", g), {out_valid[g], out_last[g], out_data[g]}, held);
        prev_stall <= out_valid[g] && !out_ready[g];
        held       <= {out_valid[g], out_last[g], out_data[g]};
      end
      if (out_last[g] && !out_valid[g]) check($sformatf("last_wo_valid%0d", g), 1, 0);
      if (ram_wren[g]) observe(g, EV_WR, ram_addr[g], ram_wdata[g], 1'b0);
      if (out_valid[g] && out_ready[g])
        observe(g, EV_OUT, out_data[g][31:16], out_data[g][15:0], out_last[g]);
      if (err[g]) observe(g, EV_ERR, 16'h0, 16'h0, 1'b0);
    end
  end

  task automatic preload(input int i, input logic [15:0] addr, input logic [15:0] data);
    pre_en[i] = 1'b1; pre_addr = addr; pre_data = data;
    @(posedge clk); #1;
    pre_en[i] = 1'b0;
  endtask

  // Returns one step after the accepting edge (cycle k = 0 after accept).
  task automatic send_cmd(input int i, input logic [1:0] op, input logic [15:0] id,
                          input logic [15:0] score);
    int n = 0;
    cmd_valid[i] = 1'b1; cmd_op[i] = op; cmd_id[i] = id; cmd_score[i] = score;
    while (!cmd_ready[i] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check($sformatf("cmd_accept%0d", i), cmd_ready[i], 1);
    @(posedge clk); #1;
    cmd_valid[i] = 1'b0;
  endtask

  // The write commits on the edge that samples ram_wren high: RAM_LAT+2 edges after accept.
  task automatic do_update(input int i, input logic [15:0] id, input logic [15:0] score,
                           input logic [15:0] wdata);
    int k = 0;
    bit ready_low = 1'b1;
    expect_ev(i, EV_WR, id, wdata, 1'b0);
    send_cmd(i, OP_UPDATE, id, score);
    while (!ram_wren[i] && k < 40) begin
      if (cmd_ready[i]) ready_low = 1'b0;
      @(posedge clk); #1; k++;
    end
    if (cmd_ready[i]) ready_low = 1'b0;
    check($sformatf("upd_latency%0d_id%0h", i, id), k + 1, lat_of(i) + 2);
    check($sformatf("ready_low%0d", i), ready_low, 1);
    @(posedge clk); #1;
    check($sformatf("ready_back%0d", i), {cmd_ready[i], ram_wren[i]}, 2'b10);
  endtask

  task automatic bad_update(input int i, input logic [15:0] id, input logic [15:0] score);
    expect_ev(i, EV_ERR, 16'h0, 16'h0, 1'b0);
    send_cmd(i, OP_UPDATE, id, score);
    check($sformatf("err_idle%0d", i), {cmd_ready[i], busy[i], err[i]}, 3'b101);
    repeat (lat_of(i) + 4) @(posedge clk);
    #1;
  endtask

  task automatic do_dump(input int i, input bit toggle);
    int k = 0, first = -1, lastk = -1;
    out_ready[i] = 1'b1;
    send_cmd(i, OP_DUMP, 16'h0, 16'h0);
    while (busy[i] && k < 400) begin
      if (toggle && (k % 3 == 0)) out_ready[i] = ~out_ready[i];
      if (out_valid[i] && out_ready[i]) begin
        if (first < 0) first = k;
        lastk = k;
      end
      @(posedge clk); #1; k++;
    end
    check($sformatf("busy_fall%0d", i), k, lastk + 1);
    if (!toggle) check($sformatf("dump_rate%0d", i), lastk - first, 3 * (lat_of(i) + 2));
    out_ready[i] = 1'b1;
  endtask

  initial begin
    int k;
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b0; cmd_valid[i] = 1'b0; cmd_op[i] = 2'b00;
      cmd_id[i] = 16'h0; cmd_score[i] = 16'h0; out_ready[i] = 1'b1; pre_en[i] = 1'b0;
    end
    pre_addr = 16'h0; pre_data = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_flags%0d", i),
            {busy[i], out_valid[i], ram_wren[i], err[i], out_last[i], cmd_ready[i]}, 6'b000001);
      check($sformatf("rst_addr%0d", i), {ram_addr[i], ram_wdata[i]}, 32'h0);
      check($sformatf("rst_data%0d", i), out_data[i], 32'h0);
    end

    preload(0, 16'd5, 16'hFFF0); preload(0, 16'd6, 16'h1000); preload(0, 16'd7, 16'hFFFE);
    preload(1, 16'd3, 16'd100);  preload(1, 16'd255, 16'd7);
    preload(2, 16'd0, 16'd10);   preload(2, 16'd1, 16'd20);
    preload(2, 16'd2, 16'd30);   preload(2, 16'd3, 16'd40);
    for (int i = 0; i < N; i++) rst[i] = 1'b1;
    @(posedge clk); #1;

    // Saturating accumulate: carry clamps, no-carry passes through, exact all-ones.
    do_update(0, 16'd5, 16'h0020, 16'hFFFF);
    do_update(0, 16'd6, 16'h0234, 16'h1234);
    do_update(0, 16'd7, 16'h0001, 16'hFFFF);

    // Keep max, plus out-of-range ids on both sides of DEPTH.
    do_update(1, 16'd3, 16'd50, 16'd100);
    do_update(1, 16'd3, 16'd200, 16'd200);
    bad_update(1, 16'd300, 16'd5);
    do_update(1, 16'd255, 16'd9, 16'd9);
    bad_update(1, 16'd256, 16'd1);

    // Full dump with free-flowing and then toggling backpressure.
    for (int e = 0; e < 4; e++) expect_ev(2, EV_OUT, 16'(e), 16'(10 * (e + 1)), e == 3);
    do_dump(2, 1'b0);
    for (int e = 0; e < 4; e++) expect_ev(2, EV_OUT, 16'(e), 16'(10 * (e + 1)), e == 3);
    do_dump(2, 1'b1);

    // No-op opcodes are consumed without any activity.
    send_cmd(2, 2'b11, 16'd1, 16'd5);
    send_cmd(2, OP_NOP, 16'd1, 16'd5);
    check("nop_idle", {cmd_ready[2], busy[2]}, 2'b10);
    repeat (4) @(posedge clk);
    #1;
    bad_update(2, 16'd4, 16'd1);

    // Reset while entry 2 of a dump is stalled on the output.
    expect_ev(2, EV_OUT, 16'd0, 16'd10, 1'b0);
    expect_ev(2, EV_OUT, 16'd1, 16'd20, 1'b0);
    out_ready[2] = 1'b1;
    send_cmd(2, OP_DUMP, 16'h0, 16'h0);
    k = 0;
    while (!(out_valid[2] && out_data[2][31:16] == 16'd2) && k < 50) begin
      @(posedge clk); #1; k++;
    end
    out_ready[2] = 1'b0;
    check("mid_dump_entry2", {out_valid[2], out_data[2]}, {1'b1, 16'd2, 16'd30});
    @(posedge clk); #1;
    rst[2] = 1'b0;
    @(posedge clk); #1;
    rst[2] = 1'b1;
    check("dump_rst_flags", {out_valid[2], busy[2], ram_wren[2], out_last[2]}, 4'b0000);
    check("dump_rst_regs", {ram_addr[2], out_data[2]}, 48'h0);
    out_ready[2] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    do_update(2, 16'd2, 16'd77, 16'd77);

    // Reset during the read wait of an update: the write must never happen.
    send_cmd(1, OP_UPDATE, 16'd3, 16'd500);
    repeat (2) @(posedge clk);
    #1;
    check("upd_wait_busy", busy[1], 1);
    rst[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    check("upd_rst_flags", {busy[1], ram_wren[1], cmd_ready[1]}, 3'b001);
    repeat (8) @(posedge clk);
    #1;
    do_update(1, 16'd3, 16'd300, 16'd300);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
